fp32_mult_seq: RTL and testbench

Multi-cycle IEEE-754 single-precision multiplier that sits on the responder side of the datapath's `enable`/`done` handshake. Function tops (the 0.5·x + x²·cos(…) evaluator and its siblings) drive `enable` high with operands and wait for `done`. This block is the unit that answers. It uses an iterative radix-2 mantissa multiplier, so it trades about 28 cycles of latency for a small area footprint.

---
 rtl/fp32_pkg.sv | 25 ++
 rtl/fp32_classify.sv | 23 ++
 rtl/fp32_mult_seq.sv | 181 ++++++++++++++++++
 tb/tb_fp32_mult_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared fp32 definitions for the sequential arithmetic units.
package fp32_pkg;

  localparam int          BIAS    = 127;
  localparam int          EXP_W   = 8;
  localparam int          MAN_W   = 23;
  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_MUL,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational fp32 operand classifier: unpacked fields plus class flags.
// Subnormals are reported as zero.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0] word,
  output fp32_t       fields,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan,
  output logic        is_normal
);

  // Split the word and classify by exponent / mantissa pattern
  always_comb begin
    fields    = word;
    is_zero   = (fields.exp == '0);
    is_inf    = (fields.exp == '1) && (fields.man == '0);
    is_nan    = (fields.exp == '1) && (fields.man != '0);
    is_normal = !is_zero && (fields.exp != '1);
  end

endmodule

// File: rtl/fp32_mult_seq.sv
// Iterative fp32 multiplier answering an enable/done handshake.
// Radix-2 shift-add mantissa product, round-to-nearest-even, flush-to-zero.
module fp32_mult_seq
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done
);

  state_t state, state_nxt;

  logic [31:0]       a_q, b_q;
  fp32_t             fa, fb;
  logic              a_zero, a_inf, a_nan, a_norm;
  logic              b_zero, b_inf, b_nan, b_norm;

  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [47:0]       mcand_q;
  logic [47:0]       prod_q;
  logic [23:0]       mplier_q;
  logic [4:0]        cnt_q;
  logic [23:0]       mant_q;
  logic              g_q, r_q, s_q;

  logic              sign_ab;
  logic              special;
  logic [31:0]       special_res;
  logic signed [9:0] exp_sum;

  logic              rnd_up;
  logic [24:0]       mant_sum;
  logic [22:0]       mant_fin;
  logic signed [9:0] exp_fin;
  logic [31:0]       round_res;

  fp32_classify u_cls_a (
    .word      (a_q),
    .fields    (fa),
    .is_zero   (a_zero),
    .is_inf    (a_inf),
    .is_nan    (a_nan),
    .is_normal (a_norm)
  );

  fp32_classify u_cls_b (
    .word      (b_q),
    .fields    (fb),
    .is_zero   (b_zero),
    .is_inf    (b_inf),
    .is_nan    (b_nan),
    .is_normal (b_norm)
  );

  // Special-case result and biased exponent sum from the captured operands
  always_comb begin
    sign_ab = fa.sign ^ fb.sign;
    special = !(a_norm && b_norm);
    exp_sum = $signed({2'b00, fa.exp}) + $signed({2'b00, fb.exp}) - 10'(BIAS);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      special_res = QNAN;
    else if (a_inf || b_inf)
      special_res = POS_INF | {sign_ab, 31'b0};
    else
      special_res = {sign_ab, 31'b0};
  end

  // Round to nearest even, then range-check the final exponent
  always_comb begin
    rnd_up   = g_q && (r_q || s_q || mant_q[0]);
    mant_sum = {1'b0, mant_q} + {24'b0, rnd_up};
    if (mant_sum[24]) begin
      mant_fin = mant_sum[23:1];
      exp_fin  = exp_q + 10'sd1;
    end else begin
      mant_fin = mant_sum[22:0];
      exp_fin  = exp_q;
    end
    if (exp_fin >= 10'sd255)
      round_res = POS_INF | {sign_q, 31'b0};
    else if (exp_fin <= 10'sd0)
      round_res = {sign_q, 31'b0};
    else
      round_res = {sign_q, exp_fin[7:0], mant_fin};
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; dropping enable before DONE abandons the operation
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (enable) state_nxt = S_UNPACK;
      S_UNPACK: if (!enable)     state_nxt = S_IDLE;
                else if (special) state_nxt = S_DONE;
                else             state_nxt = S_MUL;
      S_MUL:    if (!enable)               state_nxt = S_IDLE;
                else if (cnt_q == 5'd23)   state_nxt = S_NORM;
      S_NORM:   if (!enable) state_nxt = S_IDLE;
                else         state_nxt = S_ROUND;
      S_ROUND:  if (!enable) state_nxt = S_IDLE;
                else         state_nxt = S_DONE;
      S_DONE:   if (!enable) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture, shift-add multiply, normalize, round
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      mant_q   <= '0;
      g_q      <= 1'b0;
      r_q      <= 1'b0;
      s_q      <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            a_q <= dataa;
            b_q <= datab;
          end
        end
        S_UNPACK: begin
          sign_q   <= sign_ab;
          exp_q    <= exp_sum;
          mcand_q  <= {24'b0, 1'b1, fa.man};
          mplier_q <= {1'b1, fb.man};
          prod_q   <= '0;
          cnt_q    <= '0;
          if (enable && special) result <= special_res;
        end
        S_MUL: begin
          if (mplier_q[0]) prod_q <= prod_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 5'd1;
        end
        S_NORM: begin
          // Product lies in [1,4); a set top bit means one extra exponent step
          if (prod_q[47]) begin
            mant_q <= prod_q[47:24];
            g_q    <= prod_q[23];
            r_q    <= prod_q[22];
            s_q    <= |prod_q[21:0];
            exp_q  <= exp_q + 10'sd1;
          end else begin
            mant_q <= prod_q[46:23];
            g_q    <= prod_q[22];
            r_q    <= prod_q[21];
            s_q    <= |prod_q[20:0];
          end
        end
        S_ROUND: begin
          if (enable) result <= round_res;
        end
        default: ;
      endcase
    end
  end

  assign done = (state == S_DONE);

endmodule

// File: tb/tb_fp32_mult_seq.sv
// Scoreboard bench for fp32_mult_seq with an integer-arithmetic reference.
module tb_fp32_mult_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] dataa = '0;
  logic [31:0] datab = '0;
  logic [31:0] result;
  logic        done;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          at_cyc;
  } exp_t;

  exp_t sb_q[$];

  fp32_mult_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .dataa   (dataa),
    .datab   (datab),
    .result  (result),
    .done    (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: exact integer product, rounded by remainder vs half-ulp
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output int lat);
    logic sgn;
    int ea, eb, e, sh;
    longint unsigned fa, fb, p, q, rem, half;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    sgn = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
    a_nan = (ea == 255) && (fa != 0);
    b_nan = (eb == 255) && (fb != 0);
    a_inf = (ea == 255) && (fa == 0);
    b_inf = (eb == 255) && (fb == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    lat = 2;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      r = 32'h7FC00000;
    else if (a_inf || b_inf)
      r = {sgn, 8'hFF, 23'd0};
    else if (a_zero || b_zero)
      r = {sgn, 31'd0};
    else begin
      lat = 28;
      p = (fa + 64'd8388608) * (fb + 64'd8388608);
      sh = (p >= (64'd1 << 47)) ? 24 : 23;
      e = ea + eb - 127 + (sh - 23);
      q = p >> sh;
      rem = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e >= 255)     r = {sgn, 8'hFF, 23'd0};
      else if (e <= 0)  r = {sgn, 31'd0};
      else              r = {sgn, e[7:0], q[22:0]};
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    case ($urandom_range(0, 9))
      0: case ($urandom_range(0, 4))
           0: v = 32'h7F800000;
           1: v = 32'hFF800000;
           2: v = {1'($urandom_range(0, 1)), 31'd0};
           3: v = {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 8388607))};
           default: v = {1'($urandom_range(0, 1)), 8'd0, 23'($urandom)};
         endcase
      1: v = $urandom;
      2: v = {1'($urandom_range(0, 1)), 8'($urandom_range(190, 254)), 23'($urandom)};
      3: v = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 64)), 23'($urandom)};
      default: v = {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
    endcase
    return v;
  endfunction

  // Issue one request, hold enable `hold` cycles past done, then release
  task automatic do_req(input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] er, r0;
    int lat, t;
    ref_mul(a, b, er, lat);
    @(negedge clk);
    dataa = a;
    datab = b;
    enable = 1'b1;
    sb_q.push_back('{er, cyc + lat});
    @(negedge clk);
    dataa = $urandom;
    datab = $urandom;
    t = 0;
    while (!done && t < 80) begin
      @(negedge clk);
      t++;
    end
    if (!done) check("done_timeout", {31'b0, done}, 32'd1);
    r0 = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("done_held", {31'b0, done}, 32'd1);
      check("result_held", result, r0);
    end
    enable = 1'b0;
    @(negedge clk);
    check("done_clear", {31'b0, done}, 32'd0);
  endtask

  // Monitor: compare on each rising done against the oldest expectation
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done && !prev_done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("result", result, e.res);
        check("latency_cycle", 32'(cyc), 32'(e.at_cyc));
      end
    end
    prev_done <= done;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ab_ok;
    repeat (3) @(negedge clk);
    check("reset_result", result, 32'h0);
    check("reset_done", {31'b0, done}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    do_req(32'h3F000000, 32'h40400000, 3);
    do_req(32'h43000000, 32'h3C000000, 1);
    do_req(32'hC0000000, 32'h40400000, 0);
    do_req(32'h7F800000, 32'h00000000, 2);
    do_req(32'hFF800000, 32'h40000000, 1);
    do_req(32'h3F800001, 32'h3F800001, 0);
    do_req(32'h7F000000, 32'h40000000, 1);
    do_req(32'h00800000, 32'h3F000000, 0);
    do_req(32'h7FC12345, 32'h3F800000, 0);

    // Abort after edge 10
    @(negedge clk);
    dataa = 32'h40A00000;
    datab = 32'h40A00000;
    enable = 1'b1;
    repeat (10) @(negedge clk);
    enable = 1'b0;
    ab_ok = 1'b1;
    repeat (35) begin
      @(negedge clk);
      if (done) ab_ok = 1'b0;
    end
    check("abort_no_done", {31'b0, ab_ok}, 32'd1);
    do_req(32'h40000000, 32'h40000000, 1);

    // Reset in the middle of MUL
    @(negedge clk);
    dataa = 32'h3FC00000;
    datab = 32'h40100000;
    enable = 1'b1;
    repeat (15) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_done", {31'b0, done}, 32'd0);
    check("midreset_result", result, 32'h0);
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    do_req(32'h3F000000, 32'h40400000, 1);

    for (int n = 0; n < 40; n++)
      do_req(rand_op(), rand_op(), int'($urandom_range(0, 3)));

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
